// File: rtl/multy_serializer.sv
// multy_serializer
//   Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it
//   out MSB first, holding each bit on ser_out for DIV clock cycles.
//
//   Optional feature (macro MULTY_SERIALIZER_PARITY_EN): after the last data
//   bit an extra DIV-cycle period carries the even parity (XOR) of the word.
//
//   Handshake: a word is taken at a rising edge where load_valid && load_ready.
//   load_ready is decoded from registered state only, so it never depends
//   combinationally on load_valid; load_valid while load_ready is low is ignored.
//
//   Ports:
//     clk        - system clock, rising edge
//     rst        - synchronous active-low reset
//     load_valid - data_in holds a word to serialize
//     load_ready - a word can be accepted this cycle
//     data_in    - parallel word, captured on handshake
//     ser_out    - current serial bit (registered)
//     ser_valid  - a data/parity bit is being driven (registered)
//     ser_strobe - last cycle of each bit period (decoded)
//     ser_last   - whole period of the word's final bit (registered)
//     busy       - word in progress, equals ser_valid (registered)
module multy_serializer #(
    parameter int WIDTH = 64,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_strobe,
    output logic             ser_last,
    output logic             busy
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);

`ifdef MULTY_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic parity;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;

    logic div_end;
    logic last_bit;
    logic word_end;
    logic accept;

    assign div_end  = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

    // Final cycle of the word: the only busy cycle in which a new word may load.
`ifdef MULTY_SERIALIZER_PARITY_EN
    assign word_end = (state == PARITY) && div_end;
`else
    assign word_end = (state == SHIFT) && last_bit && div_end;
`endif

    assign ser_strobe = div_end;
    assign load_ready = (state == IDLE) || word_end;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
`ifdef MULTY_SERIALIZER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else if (accept) begin
            // Also covers back-to-back: counters restart with no idle gap.
            state     <= SHIFT;
            shreg     <= data_in;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            ser_out   <= data_in[WIDTH-1];
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
            busy      <= 1'b1;
`ifdef MULTY_SERIALIZER_PARITY_EN
            parity    <= ^data_in;
`endif
        end else if (word_end) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (state != IDLE) begin
            if (!div_end) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
`ifdef MULTY_SERIALIZER_PARITY_EN
                if (state == SHIFT && last_bit) begin
                    state    <= PARITY;
                    ser_out  <= parity;
                    ser_last <= 1'b1;
                end else begin
                    shreg   <= shreg << 1;
                    ser_out <= shreg[WIDTH-2];
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
`else
                // Not the last bit here: the last bit's final cycle is word_end.
                shreg    <= shreg << 1;
                ser_out  <= shreg[WIDTH-2];
                bit_cnt  <= bit_cnt + BIT_W'(1);
                ser_last <= (bit_cnt == BIT_W'(WIDTH - 2));
`endif
            end
        end
    end

endmodule

// File: doc/multy_serializer.md
Name: multy_serializer

Overview:
- Reader-side counterpart to the 64-bit enable-gated game-state holding register.
- Accepts a parallel word over a valid/ready load handshake and shifts it out one bit at a time, MSB first.
- Each bit is held for a programmable number of clock cycles. A strobe marks the sample point and a last flag marks the word end.
- Feeds serial row/obstacle data to the display/scan path from the holding register's output.

Parameters:
- WIDTH, 64, parallel word width in bits (>= 2)
- DIV, 4, clock cycles each bit is held on ser_out (>= 1)

Ports:
- clk, input, 1, system clock; all logic is on the rising edge
- rst, input, 1, reset; synchronous and active-low (0 = reset)
- load_valid, input, 1, data_in holds a word to serialize
- load_ready, output, 1, block can accept a word this cycle
- data_in, input, WIDTH, parallel word; captured on handshake
- ser_out, output, 1, current serial bit
- ser_valid, output, 1, high for every cycle a data or parity bit is driven
- ser_strobe, output, 1, one-cycle pulse in the last cycle of each bit period
- ser_last, output, 1, high for the whole period of the final bit of a word
- busy, output, 1, word in progress (equals ser_valid)

Behaviour:
- Reset: rst sampled low at a rising edge forces state IDLE.
  - ser_out, ser_valid, ser_strobe, ser_last and busy go to 0.
  - Shift register and counters clear.
- load_ready is decoded from state and counters, so it reads 1 in the cycle after reset.
- Reset has priority over everything, including mid-word. The partial word is discarded with no ser_last.
- States:
  - IDLE: load_ready=1, ser_valid=0.
  - SHIFT: shift register output active; div_cnt counts 0..DIV-1; bit_cnt counts 0..WIDTH-1 (width $clog2(WIDTH+1)).
  - PARITY: only with PARITY_EN.
- Handshake: a word is accepted at the edge where load_valid && load_ready.
  - At that edge: shreg <= data_in, div_cnt <= 0, bit_cnt <= 0, state <= SHIFT.
  - Immediately after that edge: ser_out = data_in[WIDTH-1] and ser_valid = 1.
- Bit timing: bit k (MSB = k 0) occupies cycles k*DIV .. k*DIV+DIV-1, counted from the accept edge.
  - ser_strobe = 1 when div_cnt == DIV-1.
  - When div_cnt wraps, shreg shifts left by 1 and bit_cnt increments.
  - With DIV=1, ser_strobe is high on every SHIFT cycle.
- ser_last = 1 while bit_cnt == WIDTH-1 (or during PARITY when that is enabled).
- End of word: the final cycle of the final bit period has ser_strobe=1 and ser_last=1.
  - load_ready is also 1 in that cycle.
  - If load_valid is high then, the next word is accepted. Its MSB follows with no gap: ser_valid stays 1 and the counters restart.
  - Otherwise the next state is IDLE.
- Total occupancy: WIDTH*DIV cycles per word, plus DIV more with parity enabled.
- Busy rules:
  - In SHIFT, load_ready=0 except in that final cycle.
  - load_valid while not ready is ignored and data_in is not sampled.
  - data_in changing after acceptance has no effect.
- ser_out, ser_valid, ser_last and busy are registered. ser_strobe and load_ready are decoded from registered state and counters, with no combinational path from inputs.

Optional Feature:
- Macro: MULTY_SERIALIZER_PARITY_EN.
- When defined:
  - After bit WIDTH-1, the block enters PARITY for DIV cycles.
  - ser_out = even parity (XOR of all WIDTH accepted bits), computed at accept and held in a register.
  - ser_last moves from the data MSB-last bit to the parity period.
  - The back-to-back load_ready cycle becomes the final PARITY cycle.
  - A word produces WIDTH+1 strobes.
- When undefined: no PARITY state and no parity register; behaviour is exactly as above.

Test Plan:
- Hold rst=0 for 3 cycles with load_valid=1, then release → ser_valid, ser_out, ser_strobe, ser_last and busy are 0 during reset; load_ready=1 after; no word is captured during reset.
- DIV=4, load 64'h8000_0000_0000_0001 → ser_out=1 for 4 cycles, 0 for 248 cycles, then 1 for 4 cycles with ser_last=1; exactly 64 ser_strobe pulses; load_ready returns 1 at cycle 256.
- load_valid held high with words A=64'hFFFF_0000_FFFF_0000 then B=64'h0123_4567_89AB_CDEF → B's MSB (0) appears in the cycle right after A's last strobe; ser_valid never drops; 128 strobes in 512 cycles.
- Pulse load_valid with 64'h1 on a cycle mid-word (bit 10) → no acceptance; the current word completes unchanged.
- Assert rst=0 during bit 20 → next cycle all outputs are 0 and state is IDLE; no ser_last for the aborted word; a new word loads normally afterwards.
- With MULTY_SERIALIZER_PARITY_EN, DIV=2, load 64'h7 → 64 data bits, then the parity bit = 1 for 2 cycles with ser_last=1; 65 strobes; load_ready=1 at cycle 130.
